ex_stage: RTL

Execute stage of the 5-stage RV32 pipeline. It sits between the ID/EX register and the MEM stage. It computes ALU results, branch/jump decisions and store data. It also runs an iterative RV32M multiply/divide unit that stalls upstream stages while busy. All outputs toward the MEM stage are registered, forming the EX/MEM pipeline register.

---
 rtl/ex_stage.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage RV32 pipeline.
//
// It computes the ALU result, resolves branches and jumps, and forwards store
// data and control to the MEM stage through the registered EX/MEM outputs.
// Optional RV32M unit (macro MULDIV_EN): an iterative radix-2 multiply /
// restoring-divide engine. It stalls the upstream stages while it is busy.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   valid_in            ID/EX holds a real instruction (0 = bubble)
//   pc_in, rs1_val, rs2_val, imm    instruction PC, operands, immediate
//   alu_ctrl            operation select (0..10 single-cycle, 11..18 mul/div)
//   ALUSrc, use_pc      operand B = imm, operand A = pc
//   is_branch, funct3   conditional branch and its condition
//   is_jal, is_jalr     jump type
//   MemRead, MemWrite, RegWrite, MemtoReg, rd_in    control passed through
//   ALU_out, store_data_out, *_out, rd_out          EX/MEM register
//   branch_taken, branch_target                     combinational redirect
//   stall_out           combinational hold request for ID/EX and earlier
//
// Stall/hold semantics: while stall_out is high, the upstream stages keep the
// same instruction on the inputs, and EX/MEM loads a bubble.
module ex_stage #(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      alu_ctrl,
  input  logic            ALUSrc,
  input  logic            use_pc,
  input  logic            is_branch,
  input  logic [2:0]      funct3,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            RegWrite,
  input  logic            MemtoReg,
  input  logic [4:0]      rd_in,
  output logic [XLEN-1:0] ALU_out,
  output logic [XLEN-1:0] store_data_out,
  output logic            MemRead_out,
  output logic            MemWrite_out,
  output logic            RegWrite_out,
  output logic            MemtoReg_out,
  output logic [4:0]      rd_out,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic            stall_out
);

  localparam logic [4:0] ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_SLL = 5'd2,
                         ALU_SLT = 5'd3,  ALU_SLTU = 5'd4, ALU_XOR = 5'd5,
                         ALU_SRL = 5'd6,  ALU_SRA = 5'd7,  ALU_OR = 5'd8,
                         ALU_AND = 5'd9,  ALU_PASSB = 5'd10;

  logic [XLEN-1:0] op_a, op_b, alu_res, result;
  logic            cond;

  assign op_a = use_pc ? pc_in : rs1_val;
  assign op_b = ALUSrc ? imm : rs2_val;

  // Single-cycle ALU; codes 11..31 yield 0 here.
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_SLL:   alu_res = op_a << op_b[4:0];
      ALU_SLT:   alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_res = {31'b0, op_a < op_b};
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SRL:   alu_res = op_a >> op_b[4:0];
      ALU_SRA:   alu_res = $signed(op_a) >>> op_b[4:0];
      ALU_OR:    alu_res = op_a | op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_PASSB: alu_res = op_b;
      default:   alu_res = '0;
    endcase
  end

  // Branch condition; funct3 010/011 are undefined and never taken.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = (rs1_val == rs2_val);
      3'b001:  cond = (rs1_val != rs2_val);
      3'b100:  cond = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  cond = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  cond = (rs1_val < rs2_val);
      3'b111:  cond = (rs1_val >= rs2_val);
      default: cond = 1'b0;
    endcase
  end

  assign branch_target = is_jalr ? ((rs1_val + imm) & ~32'd1) : (pc_in + imm);
  assign branch_taken  = valid_in && !stall_out &&
                         (is_jal || is_jalr || (is_branch && cond));

`ifdef MULDIV_EN
  localparam logic [4:0] ALU_MUL = 5'd11, ALU_MULH = 5'd12, ALU_MULHSU = 5'd13,
                         ALU_MULHU = 5'd14, ALU_DIV = 5'd15, ALU_DIVU = 5'd16,
                         ALU_REM = 5'd17, ALU_REMU = 5'd18;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

  md_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d, op_q, op_d;
  logic [63:0] acc_q, acc_d;        // mul: {partial, multiplier}; div: {rem, quo}
  logic [31:0] b_q, b_d;            // multiplicand / divisor magnitude
  logic        neg_q, neg_d;        // product / quotient sign
  logic        neg_rem_q, neg_rem_d;
  logic        div_zero_q, div_zero_d;

  logic        md_op, md_start, a_signed, b_signed, neg_a, neg_b;
  logic [31:0] mag_a, mag_b, quo, rem, md_result;
  logic [32:0] mul_sum, div_diff;
  logic [63:0] mul_step, div_step, prod;

  assign md_op    = (alu_ctrl >= ALU_MUL) && (alu_ctrl <= ALU_REMU);
  assign md_start = (state_q == MD_IDLE) && valid_in && md_op;
  assign stall_out = md_start || (state_q == MD_BUSY);

  assign a_signed = (alu_ctrl == ALU_MULH) || (alu_ctrl == ALU_MULHSU) ||
                    (alu_ctrl == ALU_DIV)  || (alu_ctrl == ALU_REM);
  assign b_signed = (alu_ctrl == ALU_MULH) || (alu_ctrl == ALU_DIV) ||
                    (alu_ctrl == ALU_REM);
  assign neg_a = a_signed && op_a[31];
  assign neg_b = b_signed && op_b[31];
  assign mag_a = neg_a ? -op_a : op_a;
  assign mag_b = neg_b ? -op_b : op_b;

  // One shift-add step: add multiplicand on LSB, then shift right.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
  assign mul_step = {mul_sum, acc_q[31:1]};
  // One restoring step on the left-shifted {rem, quo} pair.
  assign div_diff = acc_q[63:31] - {1'b0, b_q};
  assign div_step = div_diff[32] ? {acc_q[62:0], 1'b0}
                                 : {div_diff[31:0], acc_q[30:0], 1'b1};

  // Sign correction after iteration; a zero divisor forces an all-ones
  // quotient, and the remainder naturally returns the dividend.
  assign prod = neg_q ? -acc_q : acc_q;
  assign quo  = div_zero_q ? 32'hFFFF_FFFF
                           : (neg_q ? -acc_q[31:0] : acc_q[31:0]);
  assign rem  = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];

  always_comb begin
    md_result = '0;
    case (op_q)
      ALU_MUL:                         md_result = prod[31:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: md_result = prod[63:32];
      ALU_DIV, ALU_DIVU:               md_result = quo;
      ALU_REM, ALU_REMU:               md_result = rem;
      default:                         md_result = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    b_d        = b_q;
    op_d       = op_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
          state_d    = MD_BUSY;
          cnt_d      = '0;
          op_d       = alu_ctrl;
          acc_d      = {32'b0, mag_a};
          b_d        = mag_b;
          neg_d      = neg_a ^ neg_b;
          neg_rem_d  = neg_a;
          div_zero_d = (op_b == '0);
        end
      end
      MD_BUSY: begin
        acc_d = (op_q >= ALU_DIV) ? div_step : mul_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(MD_CYCLES - 1)) state_d = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      b_q        <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
    end
  end

  // The held mul/div instruction writes its result at the edge ending DONE.
  assign result = (is_jal || is_jalr) ? (pc_in + 32'd4)
                : (md_op ? md_result : alu_res);
`else
  assign stall_out = 1'b0;
  assign result    = (is_jal || is_jalr) ? (pc_in + 32'd4) : alu_res;
`endif

  // EX/MEM pipeline register. Bubbles clear everything, so a held
  // instruction never repeats a MEM access or a register write.
  logic            bubble;
  logic [XLEN-1:0] alu_out_q, alu_out_d, store_q, store_d;
  logic [4:0]      rd_q, rd_d;
  logic [3:0]      ctl_q, ctl_d;    // {MemRead, MemWrite, RegWrite, MemtoReg}

  assign bubble = !valid_in || stall_out;

  always_comb begin
    alu_out_d = '0;
    store_d   = '0;
    rd_d      = '0;
    ctl_d     = '0;
    if (!bubble) begin
      alu_out_d = result;
      store_d   = rs2_val;
      rd_d      = rd_in;
      ctl_d     = {MemRead, MemWrite, RegWrite, MemtoReg};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_q <= '0;
      store_q   <= '0;
      rd_q      <= '0;
      ctl_q     <= '0;
    end else begin
      alu_out_q <= alu_out_d;
      store_q   <= store_d;
      rd_q      <= rd_d;
      ctl_q     <= ctl_d;
    end
  end

  assign ALU_out        = alu_out_q;
  assign store_data_out = store_q;
  assign rd_out         = rd_q;
  assign MemRead_out    = ctl_q[3];
  assign MemWrite_out   = ctl_q[2];
  assign RegWrite_out   = ctl_q[1];
  assign MemtoReg_out   = ctl_q[0];

endmodule
